// File: rtl/lcd_cmd_sequencer.sv
// Character-LCD command sequencer for the io_lcd output word.
// Takes byte-wide command/data requests over valid/ready and generates
// HD44780-style bus timing: RS/DATA setup, EN pulse, hold, execution wait.
// Optional feature: define LCD_INIT_SEQ_EN to issue a built-in init sequence
// (0x38, 0x0C, 0x06, 0x01) after power-up, before the first IDLE.
module lcd_cmd_sequencer #(
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned T_PWRUP    = 750000,
    parameter int unsigned T_SETUP    = 2,
    parameter int unsigned T_EN_HIGH  = 12,
    parameter int unsigned T_HOLD     = 2,
    parameter int unsigned T_CMD_WAIT = 2000,
    parameter int unsigned T_CLR_WAIT = 82000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic        cmd_rs,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    output logic        busy,
    output logic [31:0] io_lcd
);

    // Counter reload values: a timed state lasts exactly T_x cycles.
    localparam logic [CNT_W-1:0] LdPwrup = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] LdSetup = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LdEnHi  = CNT_W'(T_EN_HIGH - 1);
    localparam logic [CNT_W-1:0] LdHold  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LdCmd   = CNT_W'(T_CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] LdClr   = CNT_W'(T_CLR_WAIT - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    typedef enum logic [2:0] {
        StPwrup,
        StIdle,
        StSetup,
        StEnHi,
        StHold,
        StWait
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             on_q;
    logic             en_q;
    logic             rs_q;
    logic [7:0]       data_q;
    logic             is_clear;

`ifdef LCD_INIT_SEQ_EN
    // INIT phase: init_q marks it, idx_q selects the ROM byte in flight.
    logic       init_q;
    logic [1:0] idx_q;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
    endfunction
`endif

    // Clear/home instructions need the long execution wait.
    assign is_clear = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

    // Handshake status decoded straight from the state register.
    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign io_lcd    = {on_q, 20'h0_0000, en_q, rs_q, 1'b0, data_q};

    // Sequencer FSM with shared down-counter and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StPwrup;
            cnt_q   <= LdPwrup;
            on_q    <= 1'b0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
`ifdef LCD_INIT_SEQ_EN
            init_q  <= 1'b1;
            idx_q   <= 2'd0;
`endif
        end else begin
            on_q <= 1'b1;
            case (state_q)
                StPwrup: begin
                    if (cnt_q == '0) begin
`ifdef LCD_INIT_SEQ_EN
                        state_q <= StSetup;
                        cnt_q   <= LdSetup;
                        rs_q    <= 1'b0;
                        data_q  <= init_byte(2'd0);
`else
                        state_q <= StIdle;
                        cnt_q   <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StIdle: begin
                    // Counter holds at zero; request bits captured only here.
                    if (cmd_valid) begin
                        state_q <= StSetup;
                        cnt_q   <= LdSetup;
                        rs_q    <= cmd_rs;
                        data_q  <= cmd_data;
                    end
                end
                StSetup: begin
                    if (cnt_q == '0) begin
                        state_q <= StEnHi;
                        cnt_q   <= LdEnHi;
                        en_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StEnHi: begin
                    if (cnt_q == '0) begin
                        state_q <= StHold;
                        cnt_q   <= LdHold;
                        en_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        state_q <= StWait;
                        cnt_q   <= is_clear ? LdClr : LdCmd;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
`ifdef LCD_INIT_SEQ_EN
                        if (init_q && idx_q != 2'd3) begin
                            // Next init byte goes straight to SETUP, no IDLE gap.
                            state_q <= StSetup;
                            cnt_q   <= LdSetup;
                            idx_q   <= idx_q + 2'd1;
                            data_q  <= init_byte(idx_q + 2'd1);
                        end else begin
                            init_q  <= 1'b0;
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end
`else
                        state_q <= StIdle;
                        cnt_q   <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule
